// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide path: data word, operation
// encoding and the result record that travels to the HI/LO register file.
package hilo_muldiv_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  typedef struct packed {
    logic  valid_hi;
    logic  valid_lo;
    word_t hi;
    word_t lo;
  } write_hilo_t;

  localparam logic [4:0] ITER_LAST = 5'd31;

  function automatic word_t abs_word(input word_t v, input logic is_signed);
    return (is_signed && v[31]) ? word_t'(-v) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// hilo_div_iter: restoring unsigned divide, one quotient bit per cycle.
// Operates on magnitudes; the controller applies sign correction afterwards.
module hilo_div_iter
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       flush,
  input  logic       step_en,
  input  logic [4:0] cnt,
  input  word_t      dividend,
  input  word_t      divisor,
  output logic       last_step,
  output word_t      quotient,
  output word_t      remainder
);

  word_t       rem_q, rem_d;
  word_t       quo_q, quo_d;
  word_t       dvs_q, dvs_d;
  logic [32:0] rem_shift;
  logic [32:0] diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  // quo_q doubles as the dividend shift register: its MSB feeds the
  // partial remainder while quotient bits enter from the bottom.
  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, dvs_q};
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    if (flush) begin
      rem_d = '0;
      quo_d = '0;
      dvs_d = '0;
    end else if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step_en) begin
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_shift[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  assign last_step = step_en && (cnt == ITER_LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO arithmetic writes.
// HILO_FAST_MULT_EN selects a single-cycle multiply instead of 32 shift-add steps.
//
// state | meaning
// IDLE  | ready for a new operation
// MUL   | shift-add multiply step per cycle
// DIV   | restoring divide step per cycle
// DONE  | result presented on out for one cycle
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  muldiv_op_t  op,
  input  word_t       src_a,
  input  word_t       src_b,
  input  logic        flush,
  output logic        busy,
  output write_hilo_t out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  word_t       src_a_q, src_a_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  word_t       mplier_q, mplier_d;

  logic        accept;
  logic        op_signed;
  word_t       a_mag, b_mag;
  logic        div_last;
  word_t       div_quo, div_rem;
  logic [63:0] prod;
  word_t       quo_fix, rem_fix;

  assign accept    = in_valid && (state_q == S_IDLE) && !flush;
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag     = abs_word(src_a, op_signed);
  assign b_mag     = abs_word(src_b, op_signed);

  hilo_div_iter u_div (
    .clk       (clk),
    .rst_n     (resetn),
    .start     (accept),
    .flush     (flush),
    .step_en   (state_q == S_DIV),
    .cnt       (cnt_q),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .last_step (div_last),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      src_a_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      src_a_q   <= src_a_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (op == OP_DIV || op == OP_DIVU) state_d = S_DIV;
`ifdef HILO_FAST_MULT_EN
            else                               state_d = S_DONE;
`else
            else                               state_d = S_MUL;
`endif
          end
        end
        S_MUL:   if (cnt_q == ITER_LAST) state_d = S_DONE;
        S_DIV:   if (div_last) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    src_a_d   = src_a_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d     = '0;
      is_div_d  = (op == OP_DIV) || (op == OP_DIVU);
      neg_res_d = op_signed && (src_a[31] ^ src_b[31]);
      neg_rem_d = op_signed && src_a[31];
      div0_d    = (src_b == '0);
      src_a_d   = src_a;
      mcand_d   = {32'd0, a_mag};
      mplier_d  = b_mag;
`ifdef HILO_FAST_MULT_EN
      acc_d     = {32'd0, a_mag} * {32'd0, b_mag};
`else
      acc_d     = '0;
`endif
    end else if (state_q == S_MUL) begin
      cnt_d    = cnt_q + 5'd1;
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
      mcand_d  = {mcand_q[62:0], 1'b0};
      mplier_d = {1'b0, mplier_q[31:1]};
    end else if (state_q == S_DIV) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  // Sign fix-up: remainder follows the dividend, quotient/product the XOR of signs.
  always_comb begin
    prod     = neg_res_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = neg_res_q ? word_t'(-div_quo) : div_quo;
    rem_fix  = neg_rem_q ? word_t'(-div_rem) : div_rem;
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    out      = '0;
    if (state_q == S_DONE && !flush) begin
      out.valid_hi = 1'b1;
      out.valid_lo = 1'b1;
      if (!is_div_q) begin
        out.hi = prod[63:32];
        out.lo = prod[31:0];
      end else if (div0_q) begin
        out.hi = src_a_q;
        out.lo = 32'hFFFF_FFFF;
      end else begin
        out.hi = rem_fix;
        out.lo = quo_fix;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: directed corner cases plus random ops
// checked against a plain-arithmetic model; honours HILO_FAST_MULT_EN.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  muldiv_op_t  op = OP_MULT;
  word_t       src_a = '0;
  word_t       src_b = '0;
  logic        in_ready;
  logic        busy;
  write_hilo_t out;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  int          out_cyc = -1;
  logic [63:0] exp_q[$];

`ifdef HILO_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  hilo_muldiv_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .out      (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: HI/LO from plain integer arithmetic, returned as {hi, lo}.
  function automatic logic [63:0] model(input muldiv_op_t o, input word_t a, input word_t b);
    longint          sa, sb, sr, sq;
    longint unsigned ua, ub, ur;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (o)
      OP_MULT:  begin sr = sa * sb; r = sr; end
      OP_MULTU: begin ur = ua * ub; r = ur; end
      OP_DIV: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  function automatic word_t pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return word_t'($urandom_range(0, 20));
      4:       return word_t'(-$urandom_range(1, 20));
      default: return word_t'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (resetn) begin
      if (busy) busy_cnt++;
      if (out.valid_hi || out.valid_lo) begin
        out_cyc = cyc;
        chk("valid_hi", {63'd0, out.valid_hi}, 64'd1);
        chk("valid_lo", {63'd0, out.valid_lo}, 64'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%h required=none", {out.hi, out.lo});
        end else begin
          chk("result", {out.hi, out.lo}, exp_q.pop_front());
        end
      end else if (out.hi != 0 || out.lo != 0) begin
        chk("out_idle_zero", {out.hi, out.lo}, 64'd0);
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=busy required=in_ready", name);
    end
  endtask

  // Called at a negedge. flush_at > 0 flushes in that iteration cycle (no out).
  task automatic run_op(input muldiv_op_t o, input word_t a, input word_t b, input int flush_at);
    int acc;
    int lat;
    wait_ready("pre_op");
    in_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    busy_cnt = 0;
    out_cyc  = -1;
    acc      = cyc;
    lat      = (FAST && (o == OP_MULT || o == OP_MULTU)) ? 1 : 33;
    if (flush_at <= 0) exp_q.push_back(model(o, a, b));
    @(negedge clk);
    in_valid = 1'b0;
    src_a    = word_t'($urandom);
    src_b    = word_t'($urandom);
    if (flush_at > 0) begin
      repeat (flush_at - 1) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
      chk("flush_busy", {63'd0, busy}, 64'd0);
    end else begin
      wait_ready("op_done");
      chk("ready_cycle", 64'(cyc - acc), 64'(lat + 1));
      chk("out_latency", 64'(out_cyc - acc), 64'(lat));
      chk("busy_cycles", 64'(busy_cnt), 64'(lat));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #2 resetn = 1'b0;
    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_out", out, '0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(OP_MULT, word_t'(-3), 32'd7, 0);
    run_op(OP_DIV, word_t'(-7), 32'd2, 0);
    run_op(OP_DIVU, 32'd7, 32'd2, 0);
    run_op(OP_DIV, 32'd5, 32'd0, 0);
    run_op(OP_DIVU, 32'd9, 32'd0, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_DIVU, 32'd100, 32'd7, 10);
    run_op(OP_DIVU, 32'd100, 32'd7, 0);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0);

    // flush together with in_valid while idle must not start an operation
    in_valid = 1'b1;
    flush    = 1'b1;
    op       = OP_DIVU;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("idle_flush_busy", {63'd0, busy}, 64'd0);

    // async reset mid-multiply, released away from the clock edge
    in_valid = 1'b1;
    op       = OP_MULTU;
    src_a    = 32'd1234;
    src_b    = 32'd5678;
    @(negedge clk);
    in_valid = 1'b0;
    if (!FAST) begin
      repeat (4) @(negedge clk);
      chk("mid_mul_busy", {63'd0, busy}, 64'd1);
    end
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("async_rst_out", out, '0);
    exp_q.delete();
    @(negedge clk);
    #3 resetn = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 30; i++) begin
      muldiv_op_t o;
      o = muldiv_op_t'($urandom_range(0, 3));
      run_op(o, pick_operand(), pick_operand(), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 33)) : 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
